// File: rtl/cpu_consts.sv
// Shared constants for the execute-stage multiplier controller.
//   - multiplier function codes
//   - mult_ctrl FSM state enum
//   - register-file geometry and the tracker slot record
package cpu_consts;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3
  } mult_func_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mult_ctrl_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } trk_slot_t;

endpackage

// File: rtl/mult_tracker.sv
// In-flight destination tracker for the pipelined multiplier.
// One slot per multiplier stage; slot 0 takes the op issued this cycle and
// the last slot lines up with the multiplier's result-valid cycle.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   stall_i                 freeze all slots
//   flush_i                 clear every valid bit
//   load_i, load_rd_i       op issued this cycle and its destination
//   rs1_addr_i, rs2_addr_i  decode sources for the RAW check
//   wb_mult_i, wb_rd_i      writeback stage holds a multiplier result for wb_rd_i
//   last_valid_o, last_rd_o last slot contents
//   empty_o                 no valid slot
//   raw_hazard_o            a nonzero source matches a pending destination
module mult_tracker
  import cpu_consts::*;
#(
  parameter int unsigned MUL_LAT = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [REG_AW-1:0] load_rd_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              wb_mult_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic              last_valid_o,
  output logic [REG_AW-1:0] last_rd_o,
  output logic              empty_o,
  output logic              raw_hazard_o
);

  trk_slot_t slots [MUL_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) slots[i] <= '0;
    end else if (flush_i) begin
      // Issue cannot coincide with flush, so clearing slot 0 loses nothing.
      for (int unsigned i = 0; i < MUL_LAT; i++) slots[i].valid <= 1'b0;
    end else if (!stall_i) begin
      slots[0].valid <= load_i;
      slots[0].rd    <= load_rd_i;
      for (int unsigned i = 1; i < MUL_LAT; i++) slots[i] <= slots[i-1];
    end
  end

  assign last_valid_o = slots[MUL_LAT-1].valid;
  assign last_rd_o    = slots[MUL_LAT-1].rd;

  logic hit1, hit2;

  always_comb begin
    hit1    = 1'b0;
    hit2    = 1'b0;
    empty_o = 1'b1;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      if (slots[i].valid) begin
        empty_o = 1'b0;
        if (slots[i].rd == rs1_addr_i) hit1 = 1'b1;
        if (slots[i].rd == rs2_addr_i) hit2 = 1'b1;
      end
    end
    if (wb_mult_i && (wb_rd_i == rs1_addr_i)) hit1 = 1'b1;
    if (wb_mult_i && (wb_rd_i == rs2_addr_i)) hit2 = 1'b1;
    // x0 is hardwired to zero and never creates a dependency.
    raw_hazard_o = (hit1 && (rs1_addr_i != '0)) || (hit2 && (rs2_addr_i != '0));
  end

endmodule

// File: rtl/mult_ctrl.sv
// Issue and writeback controller for the 64-bit pipelined multiplier.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_*                             decode multiply request (valid/ready)
//   mult_instr/func/rd_addr/opr_a/b_o issue to the multiplier
//   mult_stall_o, mult_kill_o         multiplier stall and kill
//   mult_valid_i, mult_rd_addr_i,
//   mult_res_i                        multiplier result
//   stall_i, flush_i                  global pipeline stall / squash
//   rs1_addr_i, rs2_addr_i,
//   raw_hazard_o                      RAW check against pending multiplies
//   alu_wb_*                          ALU writeback request / grant
//   wb_en_o, wb_rd_o, wb_data_o       register-file write port
//   drain_req_i, drain_done_o         drain handshake for fences / CSR ops
//   err_o                             sticky protocol error
module mult_ctrl
  import cpu_consts::*;
#(
  parameter int unsigned MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_func_i,
  input  logic [4:0]  req_rd_addr_i,
  input  logic [63:0] req_opr_a_i,
  input  logic [63:0] req_opr_b_i,
  output logic        mult_instr_o,
  output logic [2:0]  mult_func_o,
  output logic [4:0]  mult_rd_addr_o,
  output logic [63:0] mult_opr_a_o,
  output logic [63:0] mult_opr_b_o,
  output logic        mult_stall_o,
  output logic        mult_kill_o,
  input  logic        mult_valid_i,
  input  logic [4:0]  mult_rd_addr_i,
  input  logic [63:0] mult_res_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        raw_hazard_o,
  input  logic        alu_wb_valid_i,
  input  logic [4:0]  alu_wb_rd_i,
  input  logic [63:0] alu_wb_data_i,
  output logic        alu_wb_ready_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [63:0] wb_data_o,
  input  logic        drain_req_i,
  output logic        drain_done_o,
  output logic        err_o
);

  mult_ctrl_state_e state;

  logic       fire;
  logic       chk_en;
  logic       acc;
  logic       alu_fire;
  logic       wb_mult;
  logic       trk_last_valid;
  logic [4:0] trk_last_rd;
  logic       trk_empty;

  assign req_ready_o = !stall_i && !flush_i && (state == RUN);
  assign fire        = req_valid_i && req_ready_o;

  assign mult_instr_o   = fire;
  assign mult_func_o    = fire ? req_func_i    : '0;
  assign mult_rd_addr_o = fire ? req_rd_addr_i : '0;
  assign mult_opr_a_o   = fire ? req_opr_a_i   : '0;
  assign mult_opr_b_o   = fire ? req_opr_b_i   : '0;
  assign mult_stall_o   = stall_i;
  assign mult_kill_o    = flush_i;

  // A stalled multiplier holds its result, so the last slot is judged only on
  // cycles where it will actually advance; otherwise the same result would be
  // accepted repeatedly. A result meeting a flush is squashed with the rest.
  assign chk_en   = !stall_i && !flush_i;
  assign acc      = chk_en && trk_last_valid && mult_valid_i && (mult_rd_addr_i == trk_last_rd);
  assign alu_wb_ready_o = !acc && !stall_i;
  assign alu_fire = alu_wb_valid_i && alu_wb_ready_o;

  mult_tracker #(
    .MUL_LAT (MUL_LAT)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .load_i       (fire),
    .load_rd_i    (req_rd_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .wb_mult_i    (wb_mult),
    .wb_rd_i      (wb_rd_o),
    .last_valid_o (trk_last_valid),
    .last_rd_o    (trk_last_rd),
    .empty_o      (trk_empty),
    .raw_hazard_o (raw_hazard_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_en_o   <= 1'b0;
      wb_rd_o   <= '0;
      wb_data_o <= '0;
      wb_mult   <= 1'b0;
    end else begin
      wb_mult <= acc;
      if (acc) begin
        wb_en_o   <= (mult_rd_addr_i != '0);
        wb_rd_o   <= mult_rd_addr_i;
        wb_data_o <= mult_res_i;
      end else if (alu_fire) begin
        wb_en_o   <= (alu_wb_rd_i != '0);
        wb_rd_o   <= alu_wb_rd_i;
        wb_data_o <= alu_wb_data_i;
      end else begin
        wb_en_o   <= 1'b0;
      end
    end
  end

  // Invalid slot with a valid result is a flushed/reset-orphaned op: dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (chk_en && trk_last_valid &&
                 (!mult_valid_i || (mult_rd_addr_i != trk_last_rd))) begin
      err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      drain_done_o <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (drain_req_i) state <= DRAIN;
        end
        DRAIN: begin
          if (trk_empty && !acc) begin
            state        <= DONE;
            drain_done_o <= 1'b1;
          end
        end
        DONE: begin
          if (!drain_req_i) begin
            state        <= RUN;
            drain_done_o <= 1'b0;
          end
        end
        default: begin
          state        <= RUN;
          drain_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;
  import cpu_consts::*;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_func_i;
  logic [4:0]  req_rd_addr_i;
  logic [63:0] req_opr_a_i, req_opr_b_i;
  logic        mult_instr_o;
  logic [2:0]  mult_func_o;
  logic [4:0]  mult_rd_addr_o;
  logic [63:0] mult_opr_a_o, mult_opr_b_o;
  logic        mult_stall_o, mult_kill_o;
  logic        mult_valid_i;
  logic [4:0]  mult_rd_addr_i;
  logic [63:0] mult_res_i;
  logic        stall_i, flush_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        raw_hazard_o;
  logic        alu_wb_valid_i;
  logic [4:0]  alu_wb_rd_i;
  logic [63:0] alu_wb_data_i;
  logic        alu_wb_ready_o;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        drain_req_i, drain_done_o, err_o;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  logic inj;

  mult_ctrl #(.MUL_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_func_i(req_func_i),
    .req_rd_addr_i(req_rd_addr_i), .req_opr_a_i(req_opr_a_i), .req_opr_b_i(req_opr_b_i),
    .mult_instr_o(mult_instr_o), .mult_func_o(mult_func_o), .mult_rd_addr_o(mult_rd_addr_o),
    .mult_opr_a_o(mult_opr_a_o), .mult_opr_b_o(mult_opr_b_o),
    .mult_stall_o(mult_stall_o), .mult_kill_o(mult_kill_o),
    .mult_valid_i(mult_valid_i), .mult_rd_addr_i(mult_rd_addr_i), .mult_res_i(mult_res_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .raw_hazard_o(raw_hazard_o),
    .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_rd_i(alu_wb_rd_i), .alu_wb_data_i(alu_wb_data_i),
    .alu_wb_ready_o(alu_wb_ready_o),
    .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .drain_req_i(drain_req_i), .drain_done_o(drain_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [63:0] mulf(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = {64'd0, a};
    eb = {64'd0, b};
    if (f == MULH || f == MULHSU) ea = {{64{a[63]}}, a};
    if (f == MULH) eb = {{64{b[63]}}, b};
    p = ea * eb;
    return (f == MUL) ? p[63:0] : p[127:64];
  endfunction

  // Behavioural multiplier: fixed L-cycle pipe that freezes on stall and
  // ignores kill, so squashed ops still come out and must be dropped.
  logic        bm_v [L];
  logic [4:0]  bm_rd[L];
  logic [63:0] bm_d [L];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) bm_v[i] <= 1'b0;
    end else if (!stall_i) begin
      bm_v[0]  <= mult_instr_o;
      bm_rd[0] <= mult_rd_addr_o ^ {4'd0, inj};
      bm_d[0]  <= mulf(mult_func_o, mult_opr_a_o, mult_opr_b_o);
      for (int i = 1; i < L; i++) begin
        bm_v[i]  <= bm_v[i-1];
        bm_rd[i] <= bm_rd[i-1];
        bm_d[i]  <= bm_d[i-1];
      end
    end
  end
  assign mult_valid_i   = bm_v[L-1];
  assign mult_rd_addr_i = bm_rd[L-1];
  assign mult_res_i     = bm_d[L-1];

  // Scoreboard: ops by id with a life state; results come back in issue order.
  // op_st: 0 unused, 1 in flight, 2 in writeback stage, 3 retired, 4 squashed
  logic [4:0]  op_rd [256];
  logic [63:0] op_dat[256];
  int          op_st [256];
  int          q[$];
  int          next_id, wb_id, ms;   // ms: 0 run, 1 drain, 2 done
  logic        e_wb_en, e_err;
  logic [4:0]  e_wb_rd;
  logic [63:0] e_wb_data;

  always @(negedge clk) begin
    logic e_ready, fire, haz, no_inflight, acc, bad_res, e_alu;
    int pid;
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) op_st[i] = 0;
      q.delete();
      next_id = 0; wb_id = -1; ms = 0;
      e_wb_en = 1'b0; e_err = 1'b0; e_wb_rd = '0; e_wb_data = '0;
    end else begin
      chk("wb_en", wb_en_o, e_wb_en);
      if (e_wb_en) begin
        chk("wb_rd", wb_rd_o, e_wb_rd);
        chk("wb_data", wb_data_o, e_wb_data);
      end
      chk("err", err_o, e_err);
      chk("drain_done", drain_done_o, ms == 2);

      e_ready = !stall_i && !flush_i && ms == 0;
      fire = req_valid_i && e_ready;
      haz = 1'b0; no_inflight = 1'b1;
      for (int i = 0; i < 256; i++) begin
        if (op_st[i] == 1) begin
          no_inflight = 1'b0;
          if (rs1_addr_i != 0 && op_rd[i] == rs1_addr_i) haz = 1'b1;
          if (rs2_addr_i != 0 && op_rd[i] == rs2_addr_i) haz = 1'b1;
        end
      end
      if (wb_id >= 0) begin
        if (rs1_addr_i != 0 && op_rd[wb_id] == rs1_addr_i) haz = 1'b1;
        if (rs2_addr_i != 0 && op_rd[wb_id] == rs2_addr_i) haz = 1'b1;
      end
      chk("req_ready", req_ready_o, e_ready);
      chk("mult_instr", mult_instr_o, fire);
      chk("mult_stall", mult_stall_o, stall_i);
      chk("mult_kill", mult_kill_o, flush_i);
      chk("raw_hazard", raw_hazard_o, haz);
      if (fire) begin
        chk("mult_func", mult_func_o, req_func_i);
        chk("mult_rd", mult_rd_addr_o, req_rd_addr_i);
        chk("mult_a", mult_opr_a_o, req_opr_a_i);
        chk("mult_b", mult_opr_b_o, req_opr_b_i);
      end

      acc = 1'b0; bad_res = 1'b0; pid = -1;
      if (!stall_i && mult_valid_i && q.size() > 0) begin
        pid = q.pop_front();
        if (!flush_i && op_st[pid] == 1) begin
          if (mult_rd_addr_i == op_rd[pid]) acc = 1'b1;
          else bad_res = 1'b1;
        end
      end
      e_alu = !acc && !stall_i;
      chk("alu_ready", alu_wb_ready_o, e_alu);

      if (wb_id >= 0) begin op_st[wb_id] = 3; wb_id = -1; end
      if (bad_res) begin e_err = 1'b1; op_st[pid] = 3; end
      if (acc) begin
        op_st[pid] = 2; wb_id = pid;
        e_wb_en = (op_rd[pid] != 0); e_wb_rd = op_rd[pid]; e_wb_data = op_dat[pid];
      end else if (alu_wb_valid_i && e_alu) begin
        e_wb_en = (alu_wb_rd_i != 0); e_wb_rd = alu_wb_rd_i; e_wb_data = alu_wb_data_i;
      end else begin
        e_wb_en = 1'b0;
      end
      if (flush_i) for (int i = 0; i < 256; i++) if (op_st[i] == 1) op_st[i] = 4;
      if (fire) begin
        op_rd[next_id]  = req_rd_addr_i;
        op_dat[next_id] = mulf(req_func_i, req_opr_a_i, req_opr_b_i);
        op_st[next_id]  = 1;
        q.push_back(next_id);
        next_id = (next_id + 1) % 256;
      end
      case (ms)
        0: if (drain_req_i) ms = 1;
        1: if (no_inflight) ms = 2;
        default: if (!drain_req_i) ms = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
    req_valid_i = 1'b1; req_func_i = f; req_rd_addr_i = rd; req_opr_a_i = a; req_opr_b_i = b;
  endtask

  initial begin
    int k, wbc, cnt, aluc, hz, lw, dc;
    logic found;
    logic [63:0] wbd;
    reset_n = 1'b0; inj = 1'b0;
    req_valid_i = 0; req_func_i = '0; req_rd_addr_i = '0; req_opr_a_i = '0; req_opr_b_i = '0;
    stall_i = 0; flush_i = 0; rs1_addr_i = '0; rs2_addr_i = '0;
    alu_wb_valid_i = 0; alu_wb_rd_i = '0; alu_wb_data_i = '0; drain_req_i = 0;
    tick(); tick();
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_drain_done", drain_done_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_alu_ready", alu_wb_ready_o, 1);
    chk("rst_mult_instr", mult_instr_o, 0);
    reset_n = 1'b1;
    tick();

    // MUL rd5 3*7: result written 6 cycles after the fire
    rs1_addr_i = 5'd5;
    issue(MUL, 5'd5, 64'd3, 64'd7); k = cyc_n;
    tick(); req_valid_i = 0;
    chk("hazard_rs1_5_pending", raw_hazard_o, 1);
    found = 0; wbc = 0; wbd = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wb_en_o && wb_rd_o == 5) begin found = 1; wbc = cyc_n; wbd = wb_data_o; end
      else tick();
    end
    chk("mul_found", found, 1);
    chk("mul_latency", wbc - k, 6);
    chk("mul_data", wbd, 64'd21);
    tick();
    chk("hazard_rs1_5_cleared", raw_hazard_o, 0);
    rs1_addr_i = '0;

    // other function codes, back to back
    issue(MULH, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7); tick();
    issue(MULHSU, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); tick();
    issue(MULHU, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); tick();
    req_valid_i = 0;
    for (int i = 0; i < 10; i++) tick();

    // stall for 3 cycles while an op is in flight
    issue(MUL, 5'd6, 64'd2, 64'd9); k = cyc_n;
    tick(); req_valid_i = 0;
    tick(); stall_i = 1;
    tick(); tick(); tick(); stall_i = 0;
    found = 0; wbc = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wb_en_o && wb_rd_o == 6) begin found = 1; wbc = cyc_n; wbd = wb_data_o; end
      else tick();
    end
    chk("stall_latency", wbc - k, 9);
    chk("stall_data", wbd, 64'd18);
    chk("stall_err", err_o, 0);
    tick();

    // two issues then flush; ALU writebacks continue
    issue(MUL, 5'd7, 64'd4, 64'd4); tick();
    issue(MUL, 5'd8, 64'd5, 64'd5); tick();
    req_valid_i = 0; flush_i = 1;
    alu_wb_valid_i = 1; alu_wb_rd_i = 5'd9; alu_wb_data_i = 64'd99;
    tick(); flush_i = 0;
    cnt = 0; aluc = 0;
    for (int i = 0; i < 12; i++) begin
      if (wb_en_o && wb_rd_o == 9) aluc++;
      if (wb_en_o && (wb_rd_o == 7 || wb_rd_o == 8)) cnt++;
      if (i == 6) alu_wb_valid_i = 0;
      tick();
    end
    chk("flush_no_mult_wb", cnt, 0);
    chk("flush_alu_wb_count", aluc, 7);
    chk("flush_err", err_o, 0);

    // ALU request in the same cycle a multiplier result arrives
    issue(MUL, 5'd10, 64'd6, 64'd7); tick(); req_valid_i = 0;
    tick(); tick(); tick(); tick();
    alu_wb_valid_i = 1; alu_wb_rd_i = 5'd11; alu_wb_data_i = 64'd55;
    chk("coll_alu_ready_low", alu_wb_ready_o, 0);
    tick();
    chk("coll_mult_first_en", wb_en_o, 1);
    chk("coll_mult_first_rd", wb_rd_o, 10);
    chk("coll_mult_first_data", wb_data_o, 64'd42);
    chk("coll_alu_ready_next", alu_wb_ready_o, 1);
    tick(); alu_wb_valid_i = 0;
    chk("coll_alu_wb_rd", wb_rd_o, 11);
    chk("coll_alu_wb_data", wb_data_o, 64'd55);
    tick();

    // rd = x0: no write, no hazard
    rs1_addr_i = '0; rs2_addr_i = '0;
    issue(MUL, 5'd0, 64'd5, 64'd5); tick(); req_valid_i = 0;
    cnt = 0; hz = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_en_o) cnt++;
      if (raw_hazard_o) hz++;
      tick();
    end
    chk("x0_no_write", cnt, 0);
    chk("x0_no_hazard", hz, 0);

    // drain with two ops in flight
    rs2_addr_i = 5'd13;
    issue(MUL, 5'd12, 64'd2, 64'd3); tick();
    issue(MUL, 5'd13, 64'd4, 64'd5); drain_req_i = 1; tick();
    req_valid_i = 0;
    chk("drain_blocks_issue", req_ready_o, 0);
    found = 0; lw = 0; dc = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wb_en_o && wb_rd_o == 13) lw = cyc_n;
      if (drain_done_o) begin found = 1; dc = cyc_n; end
      else tick();
    end
    chk("drain_done_seen", found, 1);
    chk("drain_done_after_wb", dc - lw, 1);
    tick();
    chk("drain_done_holds", drain_done_o, 1);
    drain_req_i = 0; tick();
    chk("drain_back_to_run", req_ready_o, 1);
    chk("drain_done_drops", drain_done_o, 0);
    rs2_addr_i = '0;
    tick();

    // result returned with the wrong destination raises sticky err_o
    issue(MUL, 5'd14, 64'd1, 64'd1); inj = 1; tick(); req_valid_i = 0; inj = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("err_sticky", err_o, 1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
